// File: rtl/systolic_out_drain.sv
// Snapshots the N x N PE accumulators when a tile completes, clears the array,
// then writes one requantized row per cycle to consecutive output RAM addresses.
module systolic_out_drain #(
    parameter int N      = 4,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [N*N*ACC_W-1:0]   acc_in,
    input  logic [4:0]             shift,
    input  logic [ADDR_W-1:0]      base_addr,
    output logic [ADDR_W-1:0]      ram_o_addr,
    output logic [N*OUT_W-1:0]     ram_o_data,
    output logic                   ram_o_wren,
    output logic [N*N-1:0]         clr_accum,
    output logic                   busy,
    output logic                   done
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;

    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [ACC_W-1:0]      snap_q [N][N];
    logic [ACC_W-1:0]      snap_d [N][N];
    logic [4:0]            shift_q, shift_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic                  done_pend_q, done_pend_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [N*OUT_W-1:0]    data_q, data_d;
    logic                  wren_q, wren_d;
    logic [N*N-1:0]        clr_q, clr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Rounding arithmetic right shift in ACC_W+1 bits so the rounding add cannot overflow.
    function automatic logic [OUT_W-1:0] requant(input logic [ACC_W-1:0] x,
                                                 input logic [4:0]       sh_in);
        int unsigned              sh;
        logic signed [ACC_W:0]    xe;
        logic signed [ACC_W:0]    rnd;
        logic signed [ACC_W:0]    y;
        sh = 32'(sh_in);
        if (sh >= ACC_W) begin
            sh = ACC_W - 1;
        end
        xe = {x[ACC_W-1], x};
        if (sh == 0) begin
            y = xe;
        end else begin
            rnd = (ACC_W+1)'(1) << (sh - 1);
            y   = (xe + rnd) >>> sh;
        end
        if (y > SAT_MAX) begin
            y = SAT_MAX;
        end else if (y < SAT_MIN) begin
            y = SAT_MIN;
        end
        return y[OUT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            snap_q      <= '{default: '0};
            shift_q     <= '0;
            base_q      <= '0;
            done_pend_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            wren_q      <= 1'b0;
            clr_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            snap_q      <= snap_d;
            shift_q     <= shift_d;
            base_q      <= base_d;
            done_pend_q <= done_pend_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wren_q      <= wren_d;
            clr_q       <= clr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // The FSM drops to IDLE while the last row is being registered, so a new
    // start can overlap the done pulse; done_pend carries that pulse one cycle on.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        snap_d      = snap_q;
        shift_d     = shift_q;
        base_d      = base_q;
        done_pend_d = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        wren_d      = 1'b0;
        clr_d       = '0;
        busy_d      = 1'b0;
        done_d      = done_pend_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int unsigned r = 0; r < N; r++) begin
                        for (int unsigned c = 0; c < N; c++) begin
                            snap_d[r][c] = acc_in[(r*N + c)*ACC_W +: ACC_W];
                        end
                    end
                    shift_d = shift;
                    base_d  = base_addr;
                    row_d   = '0;
                    clr_d   = '1;
                    busy_d  = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                busy_d = 1'b1;
                wren_d = 1'b1;
                addr_d = base_q + ADDR_W'(row_q);
                for (int unsigned c = 0; c < N; c++) begin
                    data_d[c*OUT_W +: OUT_W] = requant(snap_q[row_q][c], shift_q);
                end
                if (row_q == RW'(N - 1)) begin
                    done_pend_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ram_o_addr = addr_q;
    assign ram_o_data = data_q;
    assign ram_o_wren = wren_q;
    assign clr_accum  = clr_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_systolic_out_drain.sv
// Self-checking bench for systolic_out_drain: hand-computed requant table,
// directed corner sequences and random drains against an arithmetic reference model.
module tb_systolic_out_drain;

    localparam int N      = 4;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 16;
    localparam int ADDR_W = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [N*N*ACC_W-1:0]  acc_in;
    logic [4:0]            shift;
    logic [ADDR_W-1:0]     base_addr;
    logic [ADDR_W-1:0]     ram_o_addr;
    logic [N*OUT_W-1:0]    ram_o_data;
    logic                  ram_o_wren;
    logic [N*N-1:0]        clr_accum;
    logic                  busy;
    logic                  done;

    always #5 clk = ~clk;

    systolic_out_drain #(
        .N      (N),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .acc_in     (acc_in),
        .shift      (shift),
        .base_addr  (base_addr),
        .ram_o_addr (ram_o_addr),
        .ram_o_data (ram_o_data),
        .ram_o_wren (ram_o_wren),
        .clr_accum  (clr_accum),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [ACC_W-1:0] x;
        logic [4:0]       sh;
        logic [OUT_W-1:0] y;
    } rq_vec_t;

    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic [ADDR_W-1:0]  last_addr = '0;
    logic [N*OUT_W-1:0] last_data = '0;
    logic [N*OUT_W-1:0] first_row = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] ref_requant(input longint x, input int sh_in);
        int     sh;
        longint y;
        longint hi;
        longint lo;
        sh = (sh_in >= ACC_W) ? ACC_W - 1 : sh_in;
        if (sh == 0) y = x;
        else         y = (x + (longint'(1) << (sh - 1))) >>> sh;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        if (y > hi) y = hi;
        if (y < lo) y = lo;
        return OUT_W'(y);
    endfunction

    function automatic logic [N*OUT_W-1:0] ref_row(input logic [N*N*ACC_W-1:0] acc,
                                                   input int r, input int sh);
        logic [N*OUT_W-1:0]      res;
        logic signed [ACC_W-1:0] xs;
        longint                  x;
        res = '0;
        for (int c = 0; c < N; c++) begin
            xs = acc[(r*N + c)*ACC_W +: ACC_W];
            x  = xs;
            res[c*OUT_W +: OUT_W] = ref_requant(x, sh);
        end
        return res;
    endfunction

    function automatic logic [ACC_W-1:0] rand_elem();
        logic [ACC_W-1:0] x;
        x = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) x = -x;
        return x;
    endfunction

    task automatic fill_random();
        for (int e = 0; e < N*N; e++) acc_in[e*ACC_W +: ACC_W] = rand_elem();
    endtask

    // One drain from its start cycle (cycle 0). overlap stops checking after
    // cycle N+1 so the next drain can start in cycle N+2; rst_cyc<0 means no reset.
    task automatic drain(input string name, input logic [4:0] sh, input logic [ADDR_W-1:0] base,
                         input bit exp_done0, input bit overlap, input bit iso, input int rst_cyc);
        logic [N*N*ACC_W-1:0] snap;
        logic [N*N-1:0]       e_clr;
        logic                 e_busy, e_wren, e_done;
        int                   writes, clrs, dones, last_k;
        bit                   in_rst;
        writes = 0; clrs = 0; dones = 0; in_rst = 1'b0;
        last_k = overlap ? N + 1 : N + 3;

        @(posedge clk); #1;
        start = 1'b1; shift = sh; base_addr = base; snap = acc_in;
        @(negedge clk);
        chk({name, " c0 ctl"}, 64'({clr_accum, busy, ram_o_wren, done}),
            64'({{(N*N){1'b0}}, 1'b0, 1'b0, exp_done0}));
        chk({name, " c0 addr"}, 64'(ram_o_addr), 64'(last_addr));
        chk({name, " c0 data"}, 64'(ram_o_data), 64'(last_data));

        for (int k = 1; k <= last_k; k++) begin
            @(posedge clk); #1;
            start = iso && (k == 2 || k == 4);
            if (iso && k == 1) begin
                for (int e = 0; e < N*N; e++) acc_in[e*ACC_W +: ACC_W] = 32'h0000DEAD;
            end
            if (k == rst_cyc) begin
                rst_n  = 1'b0;
                in_rst = 1'b1;
            end
            if (rst_cyc >= 0 && k == rst_cyc + 1) rst_n = 1'b1;
            @(negedge clk);
            if (in_rst) begin
                e_clr = '0; e_busy = 1'b0; e_wren = 1'b0; e_done = 1'b0;
                last_addr = '0; last_data = '0;
            end else begin
                e_clr  = (k == 1) ? '1 : '0;
                e_busy = (k <= N + 1);
                e_wren = (k >= 2 && k <= N + 1);
                e_done = (k == N + 2);
                if (e_wren) begin
                    last_addr = base + ADDR_W'(k - 2);
                    last_data = ref_row(snap, k - 2, int'(sh));
                    if (k == 2) first_row = ram_o_data;
                end
            end
            chk({name, " ctl"}, 64'({clr_accum, busy, ram_o_wren, done}),
                64'({e_clr, e_busy, e_wren, e_done}));
            chk({name, " addr"}, 64'(ram_o_addr), 64'(last_addr));
            chk({name, " data"}, 64'(ram_o_data), 64'(last_data));
            if (ram_o_wren) writes++;
            if (clr_accum != '0) clrs++;
            if (done) dones++;
        end
        start = 1'b0;

        if (!overlap) begin
            if (rst_cyc >= 0) begin
                chk({name, " writes"}, 64'(writes), 64'((rst_cyc > 2) ? rst_cyc - 2 : 0));
                chk({name, " clr pulses"}, 64'(clrs), 64'((rst_cyc > 1) ? 1 : 0));
                chk({name, " done pulses"}, 64'(dones), 64'(0));
            end else begin
                chk({name, " writes"}, 64'(writes), 64'(N));
                chk({name, " clr pulses"}, 64'(clrs), 64'(1));
                chk({name, " done pulses"}, 64'(dones), 64'(1));
            end
        end
    endtask

    rq_vec_t tbl [18];

    initial begin
        tbl[0]  = '{32'h00000005, 5'd1,  16'h0003};
        tbl[1]  = '{32'hFFFFFFFB, 5'd1,  16'hFFFE};
        tbl[2]  = '{32'h00000006, 5'd1,  16'h0003};
        tbl[3]  = '{32'h00000007, 5'd1,  16'h0004};
        tbl[4]  = '{32'hFFFFFFFF, 5'd1,  16'h0000};
        tbl[5]  = '{32'h00000001, 5'd1,  16'h0001};
        tbl[6]  = '{32'hFFFFFFFE, 5'd1,  16'hFFFF};
        tbl[7]  = '{32'h00010000, 5'd0,  16'h7FFF};
        tbl[8]  = '{32'hFFFEEE90, 5'd0,  16'h8000};
        tbl[9]  = '{32'h00007FFF, 5'd0,  16'h7FFF};
        tbl[10] = '{32'hFFFF8000, 5'd0,  16'h8000};
        tbl[11] = '{32'h7FFFFFFF, 5'd4,  16'h7FFF};
        tbl[12] = '{32'h00008000, 5'd0,  16'h7FFF};
        tbl[13] = '{32'hFFFF7FFF, 5'd0,  16'h8000};
        tbl[14] = '{32'h80000000, 5'd31, 16'hFFFF};
        tbl[15] = '{32'h7FFFFFFF, 5'd31, 16'h0001};
        tbl[16] = '{32'hFFFFFFFD, 5'd2,  16'hFFFF};
        tbl[17] = '{32'h00000064, 5'd3,  16'h000D};

        rst_n = 1'b0; start = 1'b0; acc_in = '0; shift = '0; base_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ctl", 64'({clr_accum, busy, ram_o_wren, done}), 64'(0));
        chk("reset addr", 64'(ram_o_addr), 64'(0));
        chk("reset data", 64'(ram_o_data), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("idle ctl", 64'({clr_accum, busy, ram_o_wren, done}), 64'(0));

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                acc_in[(r*N + c)*ACC_W +: ACC_W] = ACC_W'(4*r + c);
        drain("basic", 5'd0, 8'h10, 1'b0, 1'b0, 1'b0, -1);
        chk("basic row0", 64'(first_row), 64'h0003_0002_0001_0000);
        chk("basic row3", 64'(ram_o_data), 64'h000F_000E_000D_000C);
        chk("basic last addr", 64'(ram_o_addr), 64'h13);

        for (int i = 0; i < 18; i++) begin
            for (int e = 0; e < N*N; e++) acc_in[e*ACC_W +: ACC_W] = tbl[i].x;
            drain("requant", tbl[i].sh, ADDR_W'($urandom), 1'b0, 1'b0, 1'b0, -1);
            chk($sformatf("requant tbl%0d", i), 64'(first_row), 64'({N{tbl[i].y}}));
        end

        fill_random();
        drain("wrap", 5'd3, 8'hFE, 1'b0, 1'b0, 1'b0, -1);
        chk("wrap last addr", 64'(ram_o_addr), 64'h01);

        fill_random();
        drain("isolation", 5'd2, 8'h40, 1'b0, 1'b0, 1'b1, -1);

        fill_random();
        drain("reset mid", 5'd1, 8'h20, 1'b0, 1'b0, 1'b0, 3);
        fill_random();
        drain("after reset", 5'd5, 8'h30, 1'b0, 1'b0, 1'b0, -1);

        fill_random();
        drain("b2b first", 5'd6, 8'h50, 1'b0, 1'b1, 1'b0, -1);
        fill_random();
        drain("b2b second", 5'd7, 8'h54, 1'b1, 1'b0, 1'b0, -1);

        for (int i = 0; i < 25; i++) begin
            fill_random();
            drain("random", 5'($urandom_range(0, 31)), ADDR_W'($urandom), 1'b0, 1'b0, 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
